// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the divider ratio scheduler.
// Pure declarations: no latency, no flow control.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int MIN_DIV = 2;

    function automatic logic [31:0] half(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/div_phase_cnt.sv
// Modulo-div_i phase counter: clear beats run, run=0 holds, wraps to 0 after div_i-1.
// Latency: phase_nxt_o is the value the phase takes at the next edge; no flow control.
module div_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] div_i,
    output logic [CNT_W-1:0] phase_nxt_o,
    output logic             at_last_o
);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;

    assign at_last_o   = (phase_q == div_i - CNT_W'(1));
    assign phase_nxt_o = phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (run_i) begin
            phase_d = at_last_o ? '0 : phase_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/div_ratio_sched.sv
// Runtime-programmable divider: registered q/tick, first period starts the cycle after en; ratios apply at period boundaries.
// cfg_ready is low only while a ratio is pending; DIV_GRACEFUL_STOP_EN makes en=0 finish the current period.
module div_ratio_sched #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             q_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] cur_div_o,
    output logic             pending_o,
    output logic             err_o
);
    import div_sched_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] next_div_q, next_div_d;
    logic             err_q, err_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;

    logic             xfer;
    logic             legal;
    logic             stop_req;
    logic             at_last;
    logic             cnt_clr;
    logic             cnt_run;
    logic [CNT_W-1:0] phase_nxt;
    logic [CNT_W-1:0] half_n;

    assign cfg_ready_o = (state_q != PEND);
    assign xfer        = cfg_valid_i && cfg_ready_o;
    assign legal       = (cfg_div_i >= CNT_W'(MIN_DIV));

`ifdef DIV_GRACEFUL_STOP_EN
    assign stop_req = !en_i && at_last;
`else
    assign stop_req = !en_i;
`endif

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        next_div_d = next_div_q;
        err_d      = err_q;
        if (xfer) begin
            err_d = !legal;
        end
        case (state_q)
            IDLE: begin
                if (xfer && legal) begin
                    cur_div_d = cfg_div_i;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A ratio accepted while stopping has no boundary left to wait for.
                if (stop_req) begin
                    state_d = IDLE;
                    if (xfer && legal) begin
                        cur_div_d = cfg_div_i;
                    end
                end else if (xfer && legal) begin
                    next_div_d = cfg_div_i;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (stop_req) begin
                    state_d   = IDLE;
                    cur_div_d = next_div_q;
                end else if (at_last) begin
                    state_d   = RUN;
                    cur_div_d = next_div_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_run = (state_q != IDLE);
    assign cnt_clr = (state_d == IDLE);

    div_phase_cnt #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .run_i      (cnt_run),
        .div_i      (cur_div_q),
        .phase_nxt_o(phase_nxt),
        .at_last_o  (at_last)
    );

    // q/tick are computed from the phase and ratio that will hold after the edge.
    assign half_n = CNT_W'(half(32'(cur_div_d)));
    assign q_d    = (state_d != IDLE) && (phase_nxt < half_n);
    assign tick_d = (state_d != IDLE) && (phase_nxt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cur_div_q  <= CNT_W'(DEFAULT_DIV);
            next_div_q <= CNT_W'(DEFAULT_DIV);
            err_q      <= 1'b0;
            q_q        <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            next_div_q <= next_div_d;
            err_q      <= err_d;
            q_q        <= q_d;
            tick_q     <= tick_d;
        end
    end

    assign q_o       = q_q;
    assign tick_o    = tick_q;
    assign cur_div_o = cur_div_q;
    assign pending_o = (state_q == PEND);
    assign err_o     = err_q;

endmodule

// File: tb/tb_div_ratio_sched.sv
// Bench for div_ratio_sched: spec-level cycle model feeds an expected-output queue, plus directed pattern checks.
module tb_div_ratio_sched;

    typedef struct packed {
        logic       q;
        logic       tick;
        logic [7:0] cur_div;
        logic       pending;
        logic       err;
        logic       rdy;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic [7:0] cfg_div_i = 8'd0;
    logic       cfg_ready_o;
    logic       q_o;
    logic       tick_o;
    logic [7:0] cur_div_o;
    logic       pending_o;
    logic       err_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    // model state: 0 idle, 1 running, 2 ratio pending
    int m_st = 0;
    int m_k = 0;
    int m_div = 3;
    int m_nxt = 3;
    bit m_err = 1'b0;

    always #5 clk_i = ~clk_i;

    div_ratio_sched #(
        .CNT_W      (8),
        .DEFAULT_DIV(3)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_ready_o(cfg_ready_o),
        .q_o        (q_o),
        .tick_o     (tick_o),
        .cur_div_o  (cur_div_o),
        .pending_o  (pending_o),
        .err_o      (err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit v, input int d, output exp_t x);
        bit acc, ok, last, stop;
        int ns;
        if (r) begin
            m_st = 0; m_k = 0; m_div = 3; m_nxt = 3; m_err = 1'b0;
        end else begin
            acc = v && (m_st != 2);
            ok  = (d >= 2);
            if (acc) m_err = !ok;
            if (m_st == 0) begin
                if (acc && ok) m_div = d;
                if (e) begin
                    m_st = 1;
                    m_k  = 0;
                end
            end else begin
                last = (m_k == m_div - 1);
`ifdef DIV_GRACEFUL_STOP_EN
                stop = !e && last;
`else
                stop = !e;
`endif
                ns = m_st;
                if (m_st == 2 && (last || stop)) begin
                    m_div = m_nxt;
                    ns    = 1;
                end
                if (m_st == 1 && acc && ok) begin
                    if (stop) m_div = d;
                    else begin
                        m_nxt = d;
                        ns    = 2;
                    end
                end
                m_k = last ? 0 : m_k + 1;
                if (stop) begin
                    ns  = 0;
                    m_k = 0;
                end
                m_st = ns;
            end
        end
        x.q       = (m_st != 0) && (m_k < m_div / 2);
        x.tick    = (m_st != 0) && (m_k == 0);
        x.cur_div = 8'(m_div);
        x.pending = (m_st == 2);
        x.err     = m_err;
        x.rdy     = (m_st != 2);
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int d);
        exp_t x;
        @(negedge clk_i);
        rst_i       = r;
        en_i        = e;
        cfg_valid_i = v;
        cfg_div_i   = 8'(d);
        model(r, e, v, d, x);
        sb_q.push_back(x);
        @(posedge clk_i);
        #1;
        x = sb_q.pop_front();
        check_eq("sb_q",       32'(q_o),         32'(x.q));
        check_eq("sb_tick",    32'(tick_o),      32'(x.tick));
        check_eq("sb_cur_div", 32'(cur_div_o),   32'(x.cur_div));
        check_eq("sb_pending", 32'(pending_o),   32'(x.pending));
        check_eq("sb_err",     32'(err_o),       32'(x.err));
        check_eq("sb_ready",   32'(cfg_ready_o), 32'(x.rdy));
    endtask

    task automatic run_q(input int n, output logic [31:0] qs);
        qs = '0;
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0);
            qs = {qs[30:0], q_o};
        end
    endtask

    task automatic wait_tick(output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            step(0, 1, 0, 0);
            cnt++;
            seen = tick_o;
        end
        if (!seen) check_eq("tick_timeout", 32'(cnt), 32'd0);
    endtask

    logic [31:0] qs;
    int          cnt;
    int          per;
    int          hi;
    int          dtab[8] = '{0, 1, 2, 3, 4, 5, 6, 7};

    initial begin
        repeat (2) step(1, 0, 0, 0);
        check_eq("rst_q",       32'(q_o),         32'd0);
        check_eq("rst_tick",    32'(tick_o),      32'd0);
        check_eq("rst_cur_div", 32'(cur_div_o),   32'd3);
        check_eq("rst_pending", 32'(pending_o),   32'd0);
        check_eq("rst_err",     32'(err_o),       32'd0);
        check_eq("rst_ready",   32'(cfg_ready_o), 32'd1);

        run_q(9, qs);
        check_eq("div3_pattern", qs, 32'b100100100);

        wait_tick(cnt);
        step(0, 1, 1, 5);
        check_eq("n5_pending", 32'(pending_o),   32'd1);
        check_eq("n5_ready",   32'(cfg_ready_o), 32'd0);
        check_eq("n5_cur_old", 32'(cur_div_o),   32'd3);
        wait_tick(cnt);
        check_eq("n5_apply_lat", 32'(cnt),       32'd2);
        check_eq("n5_cur_div",   32'(cur_div_o), 32'd5);
        check_eq("n5_pend_clr",  32'(pending_o), 32'd0);
        run_q(10, qs);
        check_eq("div5_pattern", qs, 32'b1000110001);

        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        check_eq("illegal_err",     32'(err_o),     32'd1);
        check_eq("illegal_cur_div", 32'(cur_div_o), 32'd5);
        check_eq("illegal_pending", 32'(pending_o), 32'd0);
        run_q(3, qs);
        check_eq("illegal_q_run", qs, 32'b001);
        step(0, 1, 1, 4);
        check_eq("n4_err_clr", 32'(err_o),     32'd0);
        check_eq("n4_pending", 32'(pending_o), 32'd1);
        wait_tick(cnt);
        check_eq("n4_apply_lat", 32'(cnt),       32'd4);
        check_eq("n4_cur_div",   32'(cur_div_o), 32'd4);
        run_q(8, qs);
        check_eq("div4_pattern", qs, 32'b10011001);

        step(0, 1, 1, 5);
        wait_tick(cnt);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check_eq("stop_q",    32'(q_o),    32'd0);
        check_eq("stop_tick", 32'(tick_o), 32'd0);
        step(0, 1, 0, 0);
`ifdef DIV_GRACEFUL_STOP_EN
        check_eq("reen_tick", 32'(tick_o), 32'd0);
        check_eq("reen_q",    32'(q_o),    32'd0);
`else
        check_eq("reen_tick", 32'(tick_o), 32'd1);
        check_eq("reen_q",    32'(q_o),    32'd1);
`endif
        repeat (6) step(0, 0, 0, 0);
        check_eq("idle_q", 32'(q_o), 32'd0);

        step(0, 0, 1, 3);
        check_eq("idle_cfg_cur", 32'(cur_div_o), 32'd3);
        check_eq("idle_cfg_pnd", 32'(pending_o), 32'd0);
        step(0, 1, 0, 0);
        check_eq("start_tick", 32'(tick_o), 32'd1);
        step(0, 1, 1, 7);
        check_eq("pend7", 32'(pending_o), 32'd1);
        step(1, 1, 0, 0);
        check_eq("rstpend_cur", 32'(cur_div_o), 32'd3);
        check_eq("rstpend_pnd", 32'(pending_o), 32'd0);
        check_eq("rstpend_q",   32'(q_o),       32'd0);
        check_eq("rstpend_rdy", 32'(cfg_ready_o), 32'd1);

        step(0, 0, 1, 255);
        check_eq("n255_cur", 32'(cur_div_o), 32'd255);
        step(0, 1, 0, 0);
        check_eq("n255_tick", 32'(tick_o), 32'd1);
        hi  = int'(q_o);
        per = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 0);
            per++;
            if (tick_o) break;
            hi += int'(q_o);
        end
        check_eq("n255_period", 32'(per), 32'd255);
        check_eq("n255_high",   32'(hi),  32'd127);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) == 0), dtab[$urandom_range(0, 7)]);
        end

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_ratio_sched.md
Name: div_ratio_sched

Overview:
- Runtime-programmable clock-divider controller. Replaces fixed divide-by-3 and divide-by-5 instances with one scheduler.
- Accepts ratio-change requests over a valid/ready handshake and applies each new ratio only at a period boundary, so no runt pulses occur.
- Produces a divided strobe `q` and a period-start `tick` for downstream logic.
- Runs in the `clk` domain, between configuration logic and divided-rate consumers.

Parameters:
- CNT_W, 8: width of the ratio and of the internal phase counter.
- DEFAULT_DIV, 3: ratio loaded at reset. Must be ≥2 and ≤2^CNT_W-1.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: run enable.
- cfg_valid, input, 1: a new ratio is offered.
- cfg_div, input, CNT_W: the offered ratio N.
- cfg_ready, output, 1: the scheduler can accept a ratio.
- q, output, 1: divided output.
- tick, output, 1: one-cycle pulse in phase 0 of each period.
- cur_div, output, CNT_W: the ratio currently in effect.
- pending, output, 1: a ratio has been accepted but not yet applied.
- err, output, 1: sticky flag, set when an illegal ratio is offered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State = IDLE.
  - Outputs: q=0, tick=0, phase=0, cur_div=DEFAULT_DIV, pending=0, err=0, cfg_ready=1.
  - rst overrides every other input, including mid-period and mid-handshake. Any pending ratio is discarded.
- States: IDLE, RUN, PEND.
- IDLE:
  - Outputs: q=0, tick=0, phase held at 0.
  - en=1 moves to RUN. Phase 0 of the first period is the cycle after en is sampled high.
- Phase numbering in RUN/PEND: with ratio N, phases k=0..N-1 cycle.
  - tick=1 iff k=0.
  - q=1 iff k < floor(N/2). Examples: N=3 gives q=100100…; N=5 gives q=1100011000…
  - q and tick are registered outputs with no combinational path from inputs.
- Handshake:
  - A transfer occurs when cfg_valid and cfg_ready are both high.
  - cfg_ready=1 in IDLE and RUN; cfg_ready=0 in PEND.
- Legal ratio (2 ≤ cfg_div):
  - In IDLE: cur_div is updated at the next edge and pending is not raised.
  - In RUN: the ratio is latched into next_div, pending=1, state moves to PEND.
  - A legal transfer also clears err.
- Illegal ratio (cfg_div = 0 or 1):
  - The transfer completes, err is set, and cur_div and state are unchanged.
- PEND:
  - The current period continues at cur_div.
  - In the cycle where k = cur_div-1: the next edge loads cur_div ← next_div, k ← 0, pending ← 0, state → RUN.
  - The first tick at the new ratio appears one cycle after the old period's last phase.
- Wrap-around: the phase counter returns to 0 after k = cur_div-1. It never exceeds cur_div-1.
- en=0 while in RUN or PEND, default build:
  - The next edge goes to IDLE with q=0, tick=0, phase=0.
  - A pending ratio is applied immediately: cur_div ← next_div, pending ← 0.
- Simultaneous events:
  - rst has highest priority.
  - Boundary apply and en fall in the same cycle: the ratio is applied and the block enters IDLE.
  - cfg_valid in the apply cycle is not accepted, because cfg_ready is 0 there. It may be accepted the cycle after.

Optional Feature:
- Macro: DIV_GRACEFUL_STOP_EN.
- Defined:
  - en=0 while in RUN or PEND does not stop immediately. The current period completes through k = cur_div-1, and IDLE is entered at the boundary.
  - A pending ratio is applied at that boundary.
  - en returning to 1 before the boundary cancels the stop.
  - q never truncates.
- Undefined: the immediate stop described in Behaviour.

Decomposition:
- Package div_sched_pkg:
  - state enum {IDLE, RUN, PEND}.
  - Constant MIN_DIV = 2.
  - Function half(N) = N >> 1.
- One sub-module, div_phase_cnt:
  - Modulo-N phase counter with hold, clear and load-at-wrap.
  - Outputs phase and an at_last flag.
  - The top level owns the FSM, the handshake and the q/tick registers.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=3 → q=1,0,0 repeating; tick every 3rd cycle starting 1 cycle after en; cur_div=3.
- In RUN at N=3, offer cfg_div=5 at phase 0 → pending=1 and cfg_ready=0 until the end of phase 2; then q=1,1,0,0,0 repeating; cur_div=5; pending=0.
- Offer cfg_div=1, then cfg_div=0 → err=1, cur_div unchanged, q pattern uninterrupted; then offer cfg_div=4 → err=0 and q=1,1,0,0 after the boundary.
- Drop en mid-period at N=5, phase 1:
  - Default build → q=0 and phase=0 the next cycle.
  - With DIV_GRACEFUL_STOP_EN → phases 2–4 complete before IDLE.
- Assert rst in PEND (N=3, next_div=7) → cur_div=3, pending=0, q=0, state IDLE the next cycle.
- cfg_div=255 with CNT_W=8 → period of 255 cycles, q high for 127 cycles, no counter overflow.
